// File: rtl/rob_pkg.sv
// Shared types and helpers for the multi-port reorder buffer.
// Only the status flags are reset; per-entry payload and old-preg storage live in separate arrays.
package rob_pkg;

    typedef struct packed {
        logic valid;
        logic done;
        logic exc;
    } rob_flags_t;

    localparam rob_flags_t FLAGS_CLEAR    = '{valid: 1'b0, done: 1'b0, exc: 1'b0};
    localparam rob_flags_t FLAGS_DISPATCH = '{valid: 1'b1, done: 1'b0, exc: 1'b0};

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra wrap bit separates a full buffer from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Builds the in-order retire mask: lane k retires only if every older lane in the head window retires.
module rob_retire_select #(
    parameter int RET_W = 4
) (
    input  logic [RET_W-1:0] win_valid,
    input  logic [RET_W-1:0] win_done,
    input  logic [RET_W-1:0] win_exc,
    input  logic             flush,
    output logic [RET_W-1:0] ret_valid
);

    logic run;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        ret_valid = '0;
        run       = !flush;
        for (int k = 0; k < RET_W; k++) begin
            run          = run && win_valid[k] && win_done[k] && !win_exc[k];
            ret_valid[k] = run;
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer with N-wide all-or-nothing dispatch, M completion ports, K-wide in-order retire,
// precise exception halt at the head and full flush.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DISP_W    = 4,
    parameter int CMPL_W    = 6,
    parameter int RET_W     = 4,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 57,
    localparam int IDX_W    = idx_width(DEPTH),
    localparam int PTR_W    = ptr_width(DEPTH),
    localparam int DCNT_W   = $clog2(DISP_W + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DCNT_W-1:0]             i_disp_count,
    input  logic [DISP_W*PAYLOAD_W-1:0]   i_disp_payload,
    input  logic [DISP_W*PREG_W-1:0]      i_disp_old_preg,
    output logic                          o_disp_ready,
    output logic [IDX_W-1:0]              o_disp_idx,
    input  logic [CMPL_W-1:0]             i_cmpl_en,
    input  logic [CMPL_W*IDX_W-1:0]       i_cmpl_idx,
    input  logic [CMPL_W-1:0]             i_cmpl_exc,
    output logic [RET_W-1:0]              o_ret_valid,
    output logic [RET_W*PREG_W-1:0]       o_ret_old_preg,
    output logic [RET_W*PAYLOAD_W-1:0]    o_ret_payload,
    output logic                          o_exc_valid,
    output logic [IDX_W-1:0]              o_exc_idx,
    input  logic                          i_flush,
    output logic [IDX_W:0]                o_count
);

    logic [PTR_W-1:0]     head_q, tail_q, count, free_slots, ret_cnt;
    logic [IDX_W-1:0]     head_idx, tail_idx;
    logic                 disp_fire;
    logic [RET_W-1:0]     win_valid, win_done, win_exc;

    rob_flags_t           flags_q   [DEPTH];
    logic [PREG_W-1:0]    preg_q    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];

    assign head_idx   = head_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign count      = tail_q - head_q;
    // Free space uses only registered occupancy; same-cycle retires help next cycle.
    assign free_slots = PTR_W'(DEPTH) - count;

    assign o_disp_ready = (PTR_W'(i_disp_count) <= free_slots) && !i_flush;
    assign disp_fire    = o_disp_ready && (i_disp_count != '0);
    assign o_disp_idx   = tail_idx;
    assign o_count      = count;

    always_comb begin
        win_valid      = '0;
        win_done       = '0;
        win_exc        = '0;
        o_ret_old_preg = '0;
        o_ret_payload  = '0;
        for (int k = 0; k < RET_W; k++) begin
            win_valid[k] = flags_q[head_idx + IDX_W'(k)].valid;
            win_done[k]  = flags_q[head_idx + IDX_W'(k)].done;
            win_exc[k]   = flags_q[head_idx + IDX_W'(k)].exc;
            o_ret_old_preg[k*PREG_W +: PREG_W]      = preg_q[head_idx + IDX_W'(k)];
            o_ret_payload[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[head_idx + IDX_W'(k)];
        end
    end

    rob_retire_select #(.RET_W(RET_W)) u_retire_select (
        .win_valid (win_valid),
        .win_done  (win_done),
        .win_exc   (win_exc),
        .flush     (i_flush),
        .ret_valid (o_ret_valid)
    );

    assign ret_cnt     = PTR_W'(popcount(32'(o_ret_valid)));
    assign o_exc_valid = flags_q[head_idx].valid && flags_q[head_idx].done && flags_q[head_idx].exc;
    assign o_exc_idx   = head_idx;

    // NOTE: state uses non-blocking assignments so every update reads pre-edge values regardless of order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || i_flush) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                flags_q[i] <= FLAGS_CLEAR;
            end
        end else begin
            for (int p = 0; p < CMPL_W; p++) begin
                if (i_cmpl_en[p] && flags_q[i_cmpl_idx[p*IDX_W +: IDX_W]].valid) begin
                    flags_q[i_cmpl_idx[p*IDX_W +: IDX_W]].done <= 1'b1;
                    if (i_cmpl_exc[p]) begin
                        flags_q[i_cmpl_idx[p*IDX_W +: IDX_W]].exc <= 1'b1;
                    end
                end
            end
            for (int k = 0; k < RET_W; k++) begin
                if (o_ret_valid[k]) begin
                    flags_q[head_idx + IDX_W'(k)].valid <= 1'b0;
                end
            end
            for (int s = 0; s < DISP_W; s++) begin
                if (disp_fire && (DCNT_W'(s) < i_disp_count)) begin
                    flags_q[tail_idx + IDX_W'(s)] <= FLAGS_DISPATCH;
                end
            end
            head_q <= head_q + ret_cnt;
            if (disp_fire) begin
                tail_q <= tail_q + PTR_W'(i_disp_count);
            end
        end
    end

    // NOTE: data storage has no reset; the valid flag alone decides whether an entry is meaningful.
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < DISP_W; s++) begin
            if (disp_fire && (DCNT_W'(s) < i_disp_count)) begin
                preg_q[tail_idx + IDX_W'(s)]    <= i_disp_old_preg[s*PREG_W +: PREG_W];
                payload_q[tail_idx + IDX_W'(s)] <= i_disp_payload[s*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    disp_count_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        i_disp_count <= DCNT_W'(DISP_W));

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: scoreboard of dispatched entries checked at retire, plus
// directed checks of fullness, partial retire, exception halt, flush, wrap and async reset.
module tb_rob_multiport;

    localparam int DEPTH = 16, DISP_W = 4, CMPL_W = 6, RET_W = 4, PREG_W = 6, PAYLOAD_W = 57;
    localparam int IDX_W = 4;

    typedef struct {
        logic [PREG_W-1:0]    preg;
        logic [PAYLOAD_W-1:0] payload;
    } exp_t;

    logic                        i_clk;
    logic                        i_rst;
    logic [2:0]                  i_disp_count;
    logic [DISP_W*PAYLOAD_W-1:0] i_disp_payload;
    logic [DISP_W*PREG_W-1:0]    i_disp_old_preg;
    logic                        o_disp_ready;
    logic [IDX_W-1:0]            o_disp_idx;
    logic [CMPL_W-1:0]           i_cmpl_en;
    logic [CMPL_W*IDX_W-1:0]     i_cmpl_idx;
    logic [CMPL_W-1:0]           i_cmpl_exc;
    logic [RET_W-1:0]            o_ret_valid;
    logic [RET_W*PREG_W-1:0]     o_ret_old_preg;
    logic [RET_W*PAYLOAD_W-1:0]  o_ret_payload;
    logic                        o_exc_valid;
    logic [IDX_W-1:0]            o_exc_idx;
    logic                        i_flush;
    logic [IDX_W:0]              o_count;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_count = 0;

    rob_multiport #(
        .DEPTH(DEPTH), .DISP_W(DISP_W), .CMPL_W(CMPL_W),
        .RET_W(RET_W), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_disp_count    (i_disp_count),
        .i_disp_payload  (i_disp_payload),
        .i_disp_old_preg (i_disp_old_preg),
        .o_disp_ready    (o_disp_ready),
        .o_disp_idx      (o_disp_idx),
        .i_cmpl_en       (i_cmpl_en),
        .i_cmpl_idx      (i_cmpl_idx),
        .i_cmpl_exc      (i_cmpl_exc),
        .o_ret_valid     (o_ret_valid),
        .o_ret_old_preg  (o_ret_old_preg),
        .o_ret_payload   (o_ret_payload),
        .o_exc_valid     (o_exc_valid),
        .o_exc_idx       (o_exc_idx),
        .i_flush         (i_flush),
        .o_count         (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare retiring lanes with the scoreboard, then advance one clock and idle the strobes.
    task automatic tick();
        exp_t e;
        for (int k = 0; k < RET_W; k++) begin
            if (o_ret_valid[k]) begin
                if (sb.size() == 0) begin
                    check($sformatf("ret%0d_unexpected", k), 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("ret%0d_old_preg", k), 64'(o_ret_old_preg[k*PREG_W +: PREG_W]), 64'(e.preg));
                    check($sformatf("ret%0d_payload", k), 64'(o_ret_payload[k*PAYLOAD_W +: PAYLOAD_W]), 64'(e.payload));
                end
                m_count--;
            end
        end
        @(posedge i_clk);
        #1;
        if (i_flush) begin
            sb.delete();
            m_count = 0;
        end
        i_disp_count = '0;
        i_cmpl_en    = '0;
        i_cmpl_idx   = '0;
        i_cmpl_exc   = '0;
        i_flush      = 1'b0;
        #1;
    endtask

    task automatic disp(input int n, input int base);
        logic        exp_ready;
        logic [63:0] r;
        exp_t        e;
        exp_ready    = (n <= DEPTH - m_count);
        i_disp_count = 3'(n);
        for (int s = 0; s < DISP_W; s++) begin
            r = {$urandom(), $urandom()};
            i_disp_old_preg[s*PREG_W +: PREG_W]      = PREG_W'(base + s);
            i_disp_payload[s*PAYLOAD_W +: PAYLOAD_W] = r[PAYLOAD_W-1:0];
        end
        #1;
        check($sformatf("disp_ready_n%0d", n), 64'(o_disp_ready), 64'(exp_ready));
        if (exp_ready) begin
            for (int s = 0; s < n; s++) begin
                e.preg    = i_disp_old_preg[s*PREG_W +: PREG_W];
                e.payload = i_disp_payload[s*PAYLOAD_W +: PAYLOAD_W];
                sb.push_back(e);
            end
            m_count += n;
        end
    endtask

    task automatic complete(input int idx, input int port, input logic exc);
        i_cmpl_en[port]                  = 1'b1;
        i_cmpl_idx[port*IDX_W +: IDX_W]  = IDX_W'(idx);
        i_cmpl_exc[port]                 = exc;
    endtask

    initial begin
        i_rst = 1'b1;
        i_disp_count = '0; i_disp_payload = '0; i_disp_old_preg = '0;
        i_cmpl_en = '0; i_cmpl_idx = '0; i_cmpl_exc = '0; i_flush = 1'b0;
        #2;
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_ready", 64'(o_disp_ready), 64'd1);
        check("rst_ret_valid", 64'(o_ret_valid), 64'd0);
        check("rst_exc_valid", 64'(o_exc_valid), 64'd0);
        check("rst_disp_idx", 64'(o_disp_idx), 64'd0);
        @(posedge i_clk); #1; i_rst = 1'b0; #1;

        // Fill the buffer, then a fifth dispatch must be refused.
        for (int j = 0; j < 4; j++) begin
            check($sformatf("fill_disp_idx%0d", j), 64'(o_disp_idx), 64'(j * 4));
            disp(4, j * 4);
            tick();
        end
        check("full_count", 64'(o_count), 64'd16);
        check("full_disp_idx", 64'(o_disp_idx), 64'd0);
        disp(1, 60);
        tick();
        check("full_count_after_refuse", 64'(o_count), 64'd16);

        // Head blocks until idx 0 completes; then four lanes retire while full.
        complete(1, 1, 1'b0); complete(2, 2, 1'b0); complete(3, 3, 1'b0);
        tick();
        check("head_blocked", 64'(o_ret_valid), 64'b0000);
        complete(0, 0, 1'b0);
        tick();
        check("retire_all4", 64'(o_ret_valid), 64'b1111);
        disp(1, 61);
        tick();
        check("count_after_ret4", 64'(o_count), 64'd12);

        // Out-of-order completion gives a prefix mask.
        complete(4, 0, 1'b0); complete(6, 1, 1'b0); complete(7, 2, 1'b0);
        tick();
        check("ooo_prefix1", 64'(o_ret_valid), 64'b0001);
        complete(5, 3, 1'b0);
        tick();
        check("ooo_prefix3", 64'(o_ret_valid), 64'b0111);
        tick();
        check("count_after_ooo", 64'(o_count), 64'd8);

        // Exception at idx 10 halts retire until flush; duplicate-free ports, one with exc.
        complete(8, 0, 1'b0); complete(9, 1, 1'b0); complete(11, 2, 1'b0); complete(10, 3, 1'b1);
        tick();
        check("exc_pre_retire", 64'(o_ret_valid), 64'b0011);
        check("exc_not_yet", 64'(o_exc_valid), 64'd0);
        tick();
        check("exc_valid", 64'(o_exc_valid), 64'd1);
        check("exc_idx", 64'(o_exc_idx), 64'd10);
        check("exc_no_retire", 64'(o_ret_valid), 64'b0000);
        check("exc_count", 64'(o_count), 64'd6);
        tick();
        check("exc_held", 64'(o_exc_valid), 64'd1);
        check("exc_held_count", 64'(o_count), 64'd6);
        i_flush = 1'b1;
        #1;
        check("flush_ready_low", 64'(o_disp_ready), 64'd0);
        tick();
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_exc_clear", 64'(o_exc_valid), 64'd0);
        check("flush_disp_idx", 64'(o_disp_idx), 64'd0);

        // Advance head to 14, then dispatch across the wrap point.
        disp(4, 0); tick(); disp(4, 4); tick(); disp(4, 8); tick(); disp(2, 12); tick();
        for (int i = 0; i < 14; i++) begin
            complete(i, i % CMPL_W, 1'b0);
            if ((i % CMPL_W) == CMPL_W - 1 || i == 13) tick();
        end
        for (int t = 0; t < 8 && sb.size() > 0; t++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_count", 64'(o_count), 64'd0);
        check("wrap_disp_idx", 64'(o_disp_idx), 64'd14);
        disp(4, 40);
        tick();
        check("wrap_tail", 64'(o_disp_idx), 64'd2);
        check("wrap_count", 64'(o_count), 64'd4);
        complete(14, 0, 1'b0); complete(15, 1, 1'b0); complete(0, 2, 1'b0); complete(1, 3, 1'b0);
        tick();
        check("wrap_retire4", 64'(o_ret_valid), 64'b1111);
        tick();
        check("wrap_count_after", 64'(o_count), 64'd0);

        // Asynchronous reset in the middle of a dispatch cycle.
        disp(4, 50); tick(); disp(3, 54); tick();
        check("pre_rst_count", 64'(o_count), 64'd7);
        i_disp_count = 3'd4;
        #1;
        i_rst = 1'b1;
        i_disp_count = '0;
        #1;
        check("async_rst_count", 64'(o_count), 64'd0);
        check("async_rst_disp_idx", 64'(o_disp_idx), 64'd0);
        check("async_rst_ready", 64'(o_disp_ready), 64'd1);
        check("async_rst_ret", 64'(o_ret_valid), 64'd0);
        sb.delete();
        m_count = 0;
        @(posedge i_clk); #1; i_rst = 1'b0; #1;
        complete(3, 0, 1'b0);
        tick();
        check("post_rst_cmpl_ignored", 64'(o_ret_valid), 64'd0);
        check("post_rst_count", 64'(o_count), 64'd0);
        check("sb_final", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
